// File: rtl/pattern_scan_pkg.sv
// pattern_scan_pkg
//   Shared types and constants for the pattern scanner.
//   - state_t     : controller state encoding (IDLE / SCAN / DONE)
//   - pos_t       : 3-bit scan position, 0..LAST_POS
//   - NUM_POS     : number of 4-bit windows examined per byte
//   - LAST_POS    : final scan position
//   - PATTERN     : 4-bit pattern searched for in each window
//   - pos_onehot  : one-hot result bit for a given position
//   - pos_window  : 4-bit window of a byte for a given position
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [2:0] pos_t;

  localparam int         NUM_POS  = 5;
  localparam pos_t       LAST_POS = 3'd4;
  localparam logic [3:0] PATTERN  = 4'b1010;

  // Position 0 looks at the top nibble and reports on bit 4; the last
  // position looks at the bottom nibble and reports on bit 0.
  function automatic logic [7:0] pos_onehot(input pos_t p);
    pos_t sh;
    sh = LAST_POS - p;
    return 8'h01 << sh;
  endfunction

  function automatic logic [3:0] pos_window(input logic [7:0] a, input pos_t p);
    pos_t       sh;
    logic [7:0] shifted;
    sh      = LAST_POS - p;
    shifted = a >> sh;
    return shifted[3:0];
  endfunction

endpackage

// File: rtl/pattern_scan_ctrl_fsm_sub.sv
// fsm_sub
//   Combinational single-position matcher used by pattern_scan_ctrl.
//   Ports:
//     a          in  8  byte being scanned
//     sin        in  3  current scan position
//     b          out 8  one-hot match vector for this position (0 if no match)
//     next_state out 3  position to visit next (wraps to 0 after LAST_POS)
module fsm_sub
  import pattern_scan_pkg::*;
(
  input  logic [7:0] a,
  input  pos_t       sin,
  output logic [7:0] b,
  output pos_t       next_state
);

  always_comb begin
    b          = '0;
    next_state = '0;
    // Positions beyond LAST_POS never occur in normal operation; treat them
    // as a no-match and steer back to position 0.
    if (sin <= LAST_POS) begin
      if (pos_window(a, sin) == PATTERN) begin
        b = pos_onehot(sin);
      end
      if (sin != LAST_POS) begin
        next_state = sin + 3'd1;
      end
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//   Accepts one byte at a time, slides a 4-bit window across it over
//   NUM_POS cycles and reports where PATTERN was found.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for a byte; in_ready=1
//   SCAN  | one window per cycle, accumulating mask and count
//   DONE  | result presented with out_valid=1 until out_ready
//
//   Ports:
//     clk        in  1  clock, rising edge
//     rst_n      in  1  synchronous active-low reset
//     in_valid   in  1  upstream byte valid
//     in_data    in  8  byte to scan
//     in_ready   out 1  byte can be accepted this cycle
//     out_valid  out 1  result valid
//     out_ready  in  1  downstream accepts result
//     out_mask   out 8  OR of per-position one-hot matches
//     out_count  out 3  number of matching positions
//     out_found  out 1  out_count != 0
//     out_data   out 8  byte that produced the result
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_mask,
  output logic [2:0] out_count,
  output logic       out_found,
  output logic [7:0] out_data
);

  state_t     state_q;
  state_t     state_d;
  pos_t       pos_q;
  logic [7:0] mask_q;
  logic [2:0] count_q;
  logic [7:0] data_q;

  logic [7:0] match_b;
  pos_t       pos_next;
  logic [7:0] mask_acc;
  logic [2:0] count_acc;
  logic       capture;
  logic       finish;

  fsm_sub u_fsm_sub (
    .a          (data_q),
    .sin        (pos_q),
    .b          (match_b),
    .next_state (pos_next)
  );

  // The pattern cannot overlap itself more than three times in a byte, so
  // the 3-bit count cannot wrap.
  assign mask_acc  = mask_q | match_b;
  assign count_acc = count_q + {2'b00, |match_b};

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    finish    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture = 1'b1;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (pos_q == LAST_POS) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        // Retiring and accepting in the same edge keeps throughput at one
        // byte per NUM_POS+1 cycles.
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            capture = 1'b1;
            state_d = ST_SCAN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake outputs are forced low for as long as reset is held, not
    // only after the reset edge has been sampled.
    if (!rst_n) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      capture   = 1'b0;
      finish    = 1'b0;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pos_q     <= '0;
      mask_q    <= '0;
      count_q   <= '0;
      data_q    <= '0;
      out_mask  <= '0;
      out_count <= '0;
      out_found <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q <= state_d;

      if (capture) begin
        data_q  <= in_data;
        pos_q   <= '0;
        mask_q  <= '0;
        count_q <= '0;
      end else if (state_q == ST_SCAN) begin
        mask_q  <= mask_acc;
        count_q <= count_acc;
        pos_q   <= pos_next;
      end

      // Result registers load only when a scan completes, so they keep the
      // previous result while the next byte is being scanned.
      if (finish) begin
        out_mask  <= mask_acc;
        out_count <= count_acc;
        out_found <= (count_acc != 3'd0);
        out_data  <= data_q;
      end
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_mask;
  logic [2:0] out_count;
  logic       out_found;
  logic [7:0] out_data;

  pattern_scan_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_count (out_count),
    .out_found (out_found),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mask;
    logic [2:0] count;
    logic       found;
    logic [7:0] data;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   seen     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: window for position p is bits [7-p:4-p], reported on bit 4-p.
  function automatic exp_t model(input logic [7:0] d, input int acc);
    exp_t       e;
    logic [7:0] w;
    e.mask  = '0;
    e.count = '0;
    for (int p = 0; p < 5; p++) begin
      w = d >> (4 - p);
      if (w[3:0] == 4'b1010) begin
        e.mask[4-p] = 1'b1;
        e.count     = e.count + 3'd1;
      end
    end
    e.found = (e.count != 3'd0);
    e.data  = d;
    e.acc   = acc;
    return e;
  endfunction

  // Monitor: compare every cycle a result is presented, retire on handshake,
  // then record any byte accepted at the coming edge.
  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!seen) begin
          check("latency", 32'(cyc - q[0].acc), 32'd5);
          seen = 1'b1;
        end
        check("out_mask", 32'(out_mask), 32'(q[0].mask));
        check("out_count", 32'(out_count), 32'(q[0].count));
        check("out_found", 32'(out_found), 32'(q[0].found));
        check("out_data", 32'(out_data), 32'(q[0].data));
        if (!out_ready) begin
          check("hold_in_ready", 32'(in_ready), 32'd0);
        end else begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
    if (rst_n && in_valid && in_ready) begin
      q.push_back(model(in_data, cyc + 1));
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit keep, output int acc_edge);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    acc_edge = cyc;
    if (!keep) in_valid = 1'b0;
    check("accept", 32'(got), 32'd1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
    check("drained", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1, e2;
    logic [7:0] bytes_a [4];
    logic [7:0] bytes_b [4];

    bytes_a[0] = 8'hA0; bytes_a[1] = 8'h50; bytes_a[2] = 8'h0A; bytes_a[3] = 8'h00;
    bytes_b[0] = 8'h5A; bytes_b[1] = 8'h0F; bytes_b[2] = 8'hFF; bytes_b[3] = 8'h28;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_mask", 32'(out_mask), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_found", 32'(out_found), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Basic scans
    send_byte(8'hAA, 1'b0, e1);
    drain(20);
    foreach (bytes_a[i]) begin
      send_byte(bytes_a[i], 1'b0, e1);
      drain(20);
    end

    // Backpressure with in_valid asserted but ignored
    out_ready = 1'b0;
    send_byte(8'hAA, 1'b0, e1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("bp_reach_done", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_retired", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back with in_valid held
    send_byte(8'hAA, 1'b1, e1);
    send_byte(8'hA0, 1'b0, e2);
    check("b2b_spacing", 32'(e2 - e1), 32'd6);
    drain(30);

    // Reset at scan position 2
    send_byte(8'hAA, 1'b0, e1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    seen = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    send_byte(8'h50, 1'b0, e1);
    drain(20);

    // in_valid toggling with other data during SCAN
    send_byte(8'h0A, 1'b0, e1);
    for (int k = 0; k < 3; k++) begin
      in_valid = (k % 2 == 0);
      in_data  = 8'hFF ^ 8'(k);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain(20);

    // A few more patterns
    foreach (bytes_b[i]) begin
      send_byte(bytes_b[i], 1'b0, e1);
      drain(20);
    end

    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 Parameters: none; scan length (5 positions) and pattern (4'b1010) are fixed constants from pattern_scan_pkg.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  upstream byte valid.
REQ-005 in_data  input  8  byte to scan.
REQ-006 in_ready  output  1  block can accept a byte this cycle.
REQ-007 out_valid  output  1  scan result valid.
REQ-008 out_ready  input  1  downstream accepts result.
REQ-009 out_mask  output  8  OR of all per-position one-hot match vectors.
REQ-010 out_count  output  3  number of positions that matched.
REQ-011 out_found  output  1  high when out_count != 0.
REQ-012 out_data  output  8  byte that produced the result.

Function
REQ-013 Three-state FSM: IDLE, SCAN, DONE.
REQ-014 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, capture in_data, set position=0, clear mask and count, go to SCAN.
REQ-015 SCAN: in_ready=0, out_valid=0; each cycle drive the captured byte and current position into the fsm_sub instance.
REQ-016 SCAN, every cycle: mask <= mask | b; count <= count + (b != 0); position <= next_state from fsm_sub.
REQ-017 SCAN at position 4: accumulate that cycle's b, then go to DONE; exactly 5 SCAN cycles per byte.
REQ-018 Positions map one-hot: 0->bit4 (a[7:4]), 1->bit3 (a[6:3]), 2->bit2 (a[5:2]), 3->bit1 (a[4:1]), 4->bit0 (a[3:0]); out_mask[7:5] always 0.
REQ-019 out_count never exceeds 3 (pattern overlap limit), so there is no counter wrap.
REQ-020 DONE: out_valid=1; out_mask, out_count, out_found and out_data are held stable until out_ready=1.
REQ-021 Latency: byte accepted at edge N gives out_valid=1 from edge N+5.
REQ-022 DONE with out_ready=0: hold all outputs, in_ready=0; in_valid is ignored.
REQ-023 DONE with out_ready=1 and in_valid=0: go to IDLE.
REQ-024 DONE with out_ready=1 and in_valid=1: in_ready=1; result retires and the new byte is captured into SCAN in the same edge. Peak throughput is 1 byte per 6 cycles.
REQ-025 in_valid during SCAN has no effect; the upstream holds data until in_ready.
REQ-026 Output regs outside DONE retain their last value, but only out_valid qualifies them.

Reset
REQ-027 rst_n=0 sampled at an edge forces IDLE, clears position, mask, count and captured byte, and sets all outputs to 0 (including in_ready and out_valid while rst_n=0).
REQ-028 Reset mid-SCAN or in DONE aborts the scan; no out_valid pulse follows for the aborted byte.
REQ-029 First edge with rst_n=1 leaves the FSM in IDLE with in_ready=1.

Structure
REQ-030 pattern_scan_pkg holds the FSM state enum, NUM_POS=5, LAST_POS=3'd4, PATTERN=4'b1010 and the 3-bit position type.
REQ-031 Exactly one sub-module: fsm_sub, instantiated once. Its a input is the captured byte, sin is the position register, b feeds the accumulator, and next_state feeds the position update.
REQ-032 All registers are in one clocked process; FSM next-state and handshake outputs are combinational.

Verification
REQ-033 in_data=8'hAA, out_ready=1 -> out_valid 5 cycles after accept, out_mask=8'h15, out_count=3, out_found=1.
REQ-034 Bytes 8'hA0, 8'h50, 8'h0A, 8'h00 -> masks 8'h10, 8'h08, 8'h01, 8'h00; counts 1, 1, 1, 0; out_found=0 only for 8'h00.
REQ-035 Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-036 Back-to-back: in_valid held high with 8'hAA then 8'hA0 and out_ready=1 -> second byte accepted on the cycle the first result retires; results arrive 6 cycles apart.
REQ-037 rst_n=0 for one edge at SCAN position 2 -> no out_valid for that byte, in_ready=1 on the next edge, and the next byte scans correctly.
REQ-038 in_valid toggled during SCAN with other data -> result reflects only the originally captured byte.
